// File: rtl/frog_hop_if.sv
// frog_hop_if: bundles the frame tick, freeze, raw key levels and the
// hop command outputs exchanged between the keypad side and frog_hop_ctrl.
//   timer_done   one-cycle frame tick
//   freeze       synchronous abort (mirrors frog_move reset_position)
//   key_*        raw key levels, already synchronised to CLK
//   left/right/up/down  direction commands, one-hot or all-zero
//   hop_active   high while a hop is in progress
//   hop_count    saturating count of completed "up" hops
interface frog_hop_if;
    logic       timer_done;
    logic       freeze;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       hop_active;
    logic [7:0] hop_count;

    modport master (
        output timer_done, freeze, key_left, key_right, key_up, key_down,
        input  left, right, up, down, hop_active, hop_count
    );

    modport slave (
        input  timer_done, freeze, key_left, key_right, key_up, key_down,
        output left, right, up, down, hop_active, hop_count
    );
endinterface

// File: rtl/frog_hop_ctrl.sv
// frog_hop_ctrl: turns debounced key presses into fixed-length hops for
// frog_move. Each accepted press holds one direction line high for exactly
// HOP_TICKS frame ticks, followed by COOLDOWN_TICKS idle ticks. One press
// arriving while busy is buffered (last one wins).
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   bus    frog_hop_if slave: tick/freeze/keys in, commands/status out
module frog_hop_ctrl #(
    parameter int HOP_TICKS      = 10,
    parameter int COOLDOWN_TICKS = 4,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    frog_hop_if.slave   bus
);
    localparam int HW = (HOP_TICKS > 1) ? $clog2(HOP_TICKS) : 1;
    localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [HW-1:0] HOP_LAST  = HW'(HOP_TICKS - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] DEB_PRE   = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOP = 2'd1, ST_COOL = 2'd2} state_e;
    // Encoding doubles as the bit index into the key and output vectors.
    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    dir_e          pend_dir_q, pend_dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic [HW-1:0] hop_cnt_q, hop_cnt_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    logic [7:0]    hop_count_q, hop_count_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    dir_out_q, dir_out_d;
    logic          hop_active_q, hop_active_d;

    logic [3:0]    keys_s;
    logic [3:0]    ev_s;
    logic          ev_any_s;
    dir_e          win_dir_s;
    logic          pv_s;
    dir_e          pd_s;
    logic          finish_s;

    assign keys_s = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};

    // Per-key debounce counters; freeze holds them so a held key cannot retrigger.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            ev_s[i]      = 1'b0;
            if (bus.freeze || !bus.timer_done) begin
                deb_cnt_d[i] = deb_cnt_q[i];
            end else if (keys_s[i]) begin
                ev_s[i] = (deb_cnt_q[i] == DEB_PRE);
                if (deb_cnt_q[i] != DEB_MAX) begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1'b1);
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i];
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // Coincident events resolve up > down > left > right.
    always_comb begin
        ev_any_s = |ev_s;
        if (ev_s[0]) begin
            win_dir_s = DIR_UP;
        end else if (ev_s[1]) begin
            win_dir_s = DIR_DOWN;
        end else if (ev_s[2]) begin
            win_dir_s = DIR_LEFT;
        end else begin
            win_dir_s = DIR_RIGHT;
        end
    end

    // Next-state and datapath for the IDLE/HOP/COOL sequencer.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        hop_cnt_d    = hop_cnt_q;
        cool_cnt_d   = cool_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        hop_count_d  = hop_count_q;
        finish_s     = 1'b0;
        // Pending view including an event on this tick, so a press on a
        // completion tick is already visible to the completion decision.
        pv_s         = pend_valid_q | ev_any_s;
        pd_s         = ev_any_s ? win_dir_s : pend_dir_q;

        if (bus.freeze) begin
            state_d      = ST_IDLE;
            hop_cnt_d    = '0;
            cool_cnt_d   = '0;
            pend_valid_d = 1'b0;
            pend_dir_d   = DIR_UP;
        end else if (bus.timer_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_valid_q) begin
                        state_d      = ST_HOP;
                        dir_d        = pend_dir_q;
                        hop_cnt_d    = '0;
                        pend_valid_d = 1'b0;
                    end else if (ev_any_s) begin
                        state_d   = ST_HOP;
                        dir_d     = win_dir_s;
                        hop_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOP: begin
                    pend_valid_d = pv_s;
                    pend_dir_d   = pd_s;
                    if (hop_cnt_q == HOP_LAST) begin
                        if (dir_q == DIR_UP && hop_count_q != 8'hFF) begin
                            hop_count_d = hop_count_q + 8'd1;
                        end else begin
                            hop_count_d = hop_count_q;
                        end
                        if (COOLDOWN_TICKS == 0) begin
                            finish_s = 1'b1;
                        end else begin
                            state_d    = ST_COOL;
                            cool_cnt_d = '0;
                        end
                    end else begin
                        hop_cnt_d = hop_cnt_q + HW'(1'b1);
                    end
                end
                ST_COOL: begin
                    pend_valid_d = pv_s;
                    pend_dir_d   = pd_s;
                    if (cool_cnt_q == COOL_LAST) begin
                        finish_s = 1'b1;
                    end else begin
                        cool_cnt_d = cool_cnt_q + CW'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Cooldown completion chains straight into the buffered press.
            if (finish_s) begin
                pend_valid_d = 1'b0;
                if (pv_s) begin
                    state_d   = ST_HOP;
                    dir_d     = pd_s;
                    hop_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                finish_s = 1'b0;
            end
        end else begin
            state_d = state_q;
        end

        hop_active_d = (state_d == ST_HOP);
        dir_out_d    = (state_d == ST_HOP) ? (4'b0001 << dir_d) : 4'b0000;
    end

    // State, counters and registered command outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            pend_dir_q   <= DIR_UP;
            pend_valid_q <= 1'b0;
            hop_cnt_q    <= '0;
            cool_cnt_q   <= '0;
            hop_count_q  <= 8'd0;
            dir_out_q    <= 4'b0000;
            hop_active_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            hop_cnt_q    <= hop_cnt_d;
            cool_cnt_q   <= cool_cnt_d;
            hop_count_q  <= hop_count_d;
            dir_out_q    <= dir_out_d;
            hop_active_q <= hop_active_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign bus.up         = dir_out_q[0];
    assign bus.down       = dir_out_q[1];
    assign bus.left       = dir_out_q[2];
    assign bus.right      = dir_out_q[3];
    assign bus.hop_active = hop_active_q;
    assign bus.hop_count  = hop_count_q;
endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Scoreboard bench for frog_hop_ctrl. The reference model works on a tick
// timeline: a hop launched at tick L occupies ticks L+1..L+H, cooldown runs
// to tick L+H+C, and presses seen in (L, L+H+C] are buffered (last wins).
// Each predicted hop (direction, start edge, length in ticks, hop_count at
// its end) is queued; a negedge monitor pops and checks every observed hop.
module tb_frog_hop_ctrl;
    localparam int H = 10;
    localparam int C = 4;
    localparam int D = 3;

    logic CLK;
    logic RESET;
    frog_hop_if bus_if();

    frog_hop_ctrl #(.HOP_TICKS(H), .COOLDOWN_TICKS(C), .DEBOUNCE_TICKS(D)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard storage keyed by hop id.
    int exp_q[$];
    int exp_dir[int];
    int exp_start[int];
    int exp_len[int];
    int exp_cnt[int];
    int prev_cnt[int];

    // Reference model state.
    int run[4];
    bit busy;
    bit pend_v;
    int pend_d;
    int next_free;
    int tk;
    int cur_id = -1;
    int cur_L;
    int sched;
    int nid = 0;

    task automatic launch(input int d);
        nid++;
        exp_dir[nid]   = d;
        exp_start[nid] = cyc + 1;
        exp_len[nid]   = H;
        prev_cnt[nid]  = sched;
        if (d == 0 && sched < 255) sched = sched + 1;
        exp_cnt[nid]   = sched;
        exp_q.push_back(nid);
        cur_id    = nid;
        cur_L     = tk;
        next_free = tk + H + C;
        busy      = 1'b1;
        pend_v    = 1'b0;
    endtask

    task automatic model_step(input bit td, input bit fr, input bit rst, input logic [3:0] k);
        int win;
        win = -1;
        if (rst) begin
            for (int i = 0; i < 4; i++) run[i] = 0;
            busy = 1'b0; pend_v = 1'b0; sched = 0;
        end else if (fr) begin
            if (busy && cur_id >= 0 && tk < cur_L + H) begin
                exp_len[cur_id] = tk - cur_L;
                sched = prev_cnt[cur_id];
                exp_cnt[cur_id] = sched;
            end
            busy = 1'b0; pend_v = 1'b0;
        end else if (td) begin
            tk++;
            for (int i = 0; i < 4; i++) begin
                run[i] = k[i] ? run[i] + 1 : 0;
                if (run[i] == D && win < 0) win = i;
            end
            if (busy) begin
                if (win >= 0) begin pend_v = 1'b1; pend_d = win; end
                if (tk == next_free) begin
                    if (pend_v) launch(pend_d);
                    else busy = 1'b0;
                end
            end else if (win >= 0) begin
                launch(win);
            end
        end
    endtask

    task automatic cycle(input bit td, input bit fr, input bit rst, input logic [3:0] k);
        @(posedge CLK);
        #1;
        RESET               = rst;
        bus_if.timer_done   = td;
        bus_if.freeze       = fr;
        bus_if.key_up       = k[0];
        bus_if.key_down     = k[1];
        bus_if.key_left     = k[2];
        bus_if.key_right    = k[3];
        model_step(td, fr, rst, k);
    endtask

    task automatic ticks(input int n, input logic [3:0] k);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, k);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops one prediction per observed hop and checks it.
    bit         mon_en = 1'b0;
    logic [3:0] prev_dirs = 4'b0000;
    logic [3:0] dirs;
    int         mon_id = -1;
    int         mon_len = 0;
    always @(negedge CLK) begin
        if (mon_en) begin
            dirs = {bus_if.right, bus_if.left, bus_if.down, bus_if.up};
            check("onehot", ($countones(dirs) > 1) ? 1 : 0, 0);
            check("hop_active", int'(bus_if.hop_active), (dirs != 4'b0000) ? 1 : 0);
            if (dirs != 4'b0000 && prev_dirs == 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hop", int'(dirs), 0);
                    mon_id = -1;
                end else begin
                    mon_id = exp_q.pop_front();
                    check("hop_dir", int'(dirs), 1 << exp_dir[mon_id]);
                    check("hop_start", cyc, exp_start[mon_id]);
                end
                mon_len = 0;
            end
            if (dirs != 4'b0000 && prev_dirs != 4'b0000 && dirs != prev_dirs)
                check("dir_change", int'(dirs), int'(prev_dirs));
            if (dirs != 4'b0000 && bus_if.timer_done) mon_len++;
            if (dirs == 4'b0000 && prev_dirs != 4'b0000 && mon_id >= 0) begin
                check("hop_len", mon_len, exp_len[mon_id]);
                check("hop_count", int'(bus_if.hop_count), exp_cnt[mon_id]);
            end
            prev_dirs = dirs;
        end
    end

    initial begin
        logic [3:0] rk;
        bit td, fr;
        RESET = 1'b1;
        bus_if.timer_done = 1'b0; bus_if.freeze = 1'b0;
        bus_if.key_up = 1'b0; bus_if.key_down = 1'b0;
        bus_if.key_left = 1'b0; bus_if.key_right = 1'b0;

        // Reset held with all keys high.
        cycle(1'b1, 1'b0, 1'b1, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 4'hF);
        @(negedge CLK);
        check("reset_dirs", int'({bus_if.right, bus_if.left, bus_if.down, bus_if.up}), 0);
        check("reset_active", int'(bus_if.hop_active), 0);
        check("reset_count", int'(bus_if.hop_count), 0);
        mon_en = 1'b1;

        // key_up held 20 ticks: exactly one hop.
        ticks(20, 4'b0001);
        ticks(10, 4'b0000);
        // key_left only 2 ticks: below debounce threshold.
        ticks(2, 4'b0100);
        ticks(10, 4'b0000);
        // up and right together: up wins, right discarded.
        ticks(5, 4'b1001);
        ticks(25, 4'b0000);
        // right pressed to an event at hop tick 5: buffered, launched after cooldown.
        ticks(3, 4'b0001);
        ticks(2, 4'b0000);
        ticks(3, 4'b1000);
        ticks(35, 4'b0000);
        // freeze mid-hop with right pending: hop aborted, pending dropped.
        ticks(3, 4'b0001);
        ticks(3, 4'b1000);
        ticks(2, 4'b0000);
        cycle(1'b0, 1'b1, 1'b0, 4'b0000);
        ticks(30, 4'b0000);

        // Randomized keys, tick spacing and occasional freeze.
        rk = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            td = ($urandom_range(0, 1) == 1);
            fr = !td && ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) rk[b] = ~rk[b];
            cycle(td, fr, 1'b0, rk);
        end
        ticks(30, 4'b0000);

        // Back-to-back up hops to saturate hop_count.
        for (int i = 0; i < 950; i++) begin
            ticks(3, 4'b0001);
            ticks(1, 4'b0000);
        end
        ticks(40, 4'b0000);
        @(negedge CLK);
        check("saturated_count", int'(bus_if.hop_count), 255);
        check("model_count", int'(bus_if.hop_count), sched);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
